// File: rtl/coin_acceptor_pkg.sv
// rtl/coin_acceptor_pkg.sv - shared types and constants for the coin acceptor front end
//   chan_state_t : per-slot debounce FSM state encoding
//   DEBOUNCE_CYCLES_DEFAULT : default stable-cycle count to accept a level change
//   AUDIT_W / sat_inc : audit counter width and saturating increment (COIN_AUDIT_EN builds)
package coin_acceptor_pkg;

  typedef enum logic [1:0] {
    LOW  = 2'b00,
    RISE = 2'b01,
    HIGH = 2'b11,
    FALL = 2'b10
  } chan_state_t;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 4;
  localparam int AUDIT_W = 16;

  function automatic logic [AUDIT_W-1:0] sat_inc(input logic [AUDIT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/coin_acceptor_if.sv
// rtl/coin_acceptor_if.sv - coin slot sensors, inhibit and accepted-coin pulses
//   nickel_raw, dime_raw : asynchronous slot sensors (high while coin present)
//   inhibit              : downstream busy, coins committed while high are rejected
//   nickel, dime         : one-cycle pulse per accepted coin
//   coin_reject          : one-cycle pulse to the coin-return gate
//   nickel_total, dime_total, reject_total : saturating audit counts (COIN_AUDIT_EN only)
//   master = sensor/downstream side, slave = coin_acceptor
interface coin_acceptor_if;

  logic nickel_raw;
  logic dime_raw;
  logic inhibit;
  logic nickel;
  logic dime;
  logic coin_reject;
`ifdef COIN_AUDIT_EN
  logic [coin_acceptor_pkg::AUDIT_W-1:0] nickel_total;
  logic [coin_acceptor_pkg::AUDIT_W-1:0] dime_total;
  logic [coin_acceptor_pkg::AUDIT_W-1:0] reject_total;
`endif

  modport master (
`ifdef COIN_AUDIT_EN
    input  nickel_total, dime_total, reject_total,
`endif
    output nickel_raw, dime_raw, inhibit,
    input  nickel, dime, coin_reject
  );

  modport slave (
`ifdef COIN_AUDIT_EN
    output nickel_total, dime_total, reject_total,
`endif
    input  nickel_raw, dime_raw, inhibit,
    output nickel, dime, coin_reject
  );

endinterface

// File: rtl/coin_debounce.sv
// rtl/coin_debounce.sv - 2-flop synchronizer plus 4-state debounce FSM for one slot
//   clk, reset : clock, synchronous active-high reset
//   i_raw      : asynchronous slot sensor
//   o_commit   : one-cycle strobe, once per debounced low-to-high excursion
//   DEBOUNCE_CYCLES must be >= 2
module coin_debounce
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_commit
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The count that would reach DEBOUNCE_CYCLES on this cycle's increment;
  // transitioning here keeps the counter strictly below the limit.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  chan_state_t   r_state;
  chan_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic          r_commit;
  logic          w_commit_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // State register; the commit strobe is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= LOW;
      r_cnt    <= '0;
      r_commit <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_commit <= w_commit_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_commit_nxt = 1'b0;
    case (r_state)
      LOW: begin
        if (r_sync2) begin
          w_state_nxt = RISE;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      RISE: begin
        if (!r_sync2) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt  = HIGH;
          w_cnt_nxt    = '0;
          w_commit_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!r_sync2) begin
          w_state_nxt = FALL;
          w_cnt_nxt   = CNT_W'(1);
        end
      end
      FALL: begin
        if (r_sync2) begin
          w_state_nxt = HIGH;
          w_cnt_nxt   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = LOW;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = LOW;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    o_commit = r_commit;
  end

endmodule

// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - debounced coin front end with inhibit/collision reject stage
//   clk, reset : clock, synchronous active-high reset
//   bus        : coin_acceptor_if.slave (raw sensors, inhibit, nickel/dime/coin_reject pulses)
//   Optional macro COIN_AUDIT_EN adds saturating nickel/dime/reject totals on bus.
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  coin_acceptor_if.slave  bus
);

  logic w_n_commit;
  logic w_d_commit;
  logic w_nickel_nxt;
  logic w_dime_nxt;
  logic w_reject_nxt;
  logic r_nickel;
  logic r_dime;
  logic r_reject;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel_db (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (bus.nickel_raw),
    .o_commit (w_n_commit)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime_db (
    .clk      (clk),
    .reset    (reset),
    .i_raw    (bus.dime_raw),
    .o_commit (w_d_commit)
  );

  // inhibit only matters in the commit cycle; a simultaneous commit is
  // ambiguous and goes back to the customer whatever inhibit says.
  assign w_nickel_nxt = w_n_commit & ~w_d_commit & ~bus.inhibit;
  assign w_dime_nxt   = w_d_commit & ~w_n_commit & ~bus.inhibit;
  assign w_reject_nxt = (w_n_commit | w_d_commit) & (bus.inhibit | (w_n_commit & w_d_commit));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_nickel <= 1'b0;
      r_dime   <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_nickel <= w_nickel_nxt;
      r_dime   <= w_dime_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  assign bus.nickel      = r_nickel;
  assign bus.dime        = r_dime;
  assign bus.coin_reject = r_reject;

`ifdef COIN_AUDIT_EN
  logic [AUDIT_W-1:0] r_nickel_total;
  logic [AUDIT_W-1:0] r_dime_total;
  logic [AUDIT_W-1:0] r_reject_total;

  // Keyed off the next-pulse terms so each total moves on the same edge its pulse rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_nickel_total <= '0;
      r_dime_total   <= '0;
      r_reject_total <= '0;
    end else begin
      r_nickel_total <= sat_inc(r_nickel_total, w_nickel_nxt);
      r_dime_total   <= sat_inc(r_dime_total, w_dime_nxt);
      r_reject_total <= sat_inc(r_reject_total, w_reject_nxt);
    end
  end

  assign bus.nickel_total = r_nickel_total;
  assign bus.dime_total   = r_dime_total;
  assign bus.reject_total = r_reject_total;
`endif

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - table-driven scoreboard bench for coin_acceptor (DEBOUNCE_CYCLES=4)
module tb_coin_acceptor;

  localparam logic [2:0] K_NONE = 3'b000;
  localparam logic [2:0] K_N    = 3'b001;
  localparam logic [2:0] K_D    = 3'b010;
  localparam logic [2:0] K_R    = 3'b100;
  localparam int SLEN = 32;
  localparam int NV   = 12;

  typedef struct {
    logic [31:0] n;
    logic [31:0] d;
    logic [31:0] inh;
    logic [2:0]  k0;
    int          c0;
    logic [2:0]  k1;
    int          c1;
  } vec_t;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
  } exp_t;

  logic clk;
  logic reset;
  coin_acceptor_if bus ();

  coin_acceptor #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   total = 0;
  int   bad = 0;
  int   g = 0;
  exp_t sbq[$];
  vec_t vecs[NV];
  int   exp_n = 0;
  int   exp_d = 0;
  int   exp_r = 0;

  function automatic logic [31:0] span(input int lo, input int hi);
    logic [31:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  function automatic vec_t mk(input logic [31:0] n, input logic [31:0] d, input logic [31:0] inh,
                              input logic [2:0] k0, input int c0, input logic [2:0] k1, input int c1);
    vec_t v;
    v.n = n; v.d = d; v.inh = inh;
    v.k0 = k0; v.c0 = c0; v.k1 = k1; v.c1 = c1;
    return v;
  endfunction

  function automatic logic [2:0] obs_now();
    return {bus.coin_reject, bus.dime, bus.nickel};
  endfunction

  task automatic push_exp(input logic [2:0] k, input int cyc);
    exp_t e;
    e.kind = k;
    e.cyc  = cyc;
    sbq.push_back(e);
    if (k == K_N) exp_n++;
    if (k == K_D) exp_d++;
    if (k == K_R) exp_r++;
  endtask

  task automatic check_outputs();
    logic [2:0] o;
    exp_t e;
    o = obs_now();
    if (o != K_NONE) begin
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b want=none", g, o);
      end else begin
        e = sbq.pop_front();
        if (e.kind != o || e.cyc != g) begin
          bad++;
          $display("FAIL pulse cyc=%0d got=%b want=%b@%0d", g, o, e.kind, e.cyc);
        end
      end
    end
    while (sbq.size() > 0 && sbq[0].cyc < g) begin
      e = sbq.pop_front();
      total++;
      bad++;
      $display("FAIL missing_pulse cyc=%0d got=none want=%b@%0d", g, e.kind, e.cyc);
    end
  endtask

  task automatic step(input logic n, input logic d, input logic inh, input logic rst);
    @(negedge clk);
    g++;
    check_outputs();
    bus.nickel_raw = n;
    bus.dime_raw   = d;
    bus.inhibit    = inh;
    reset          = rst;
  endtask

  task automatic expect_val(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    int base;
    reset = 1'b1;
    bus.nickel_raw = 1'b0;
    bus.dime_raw   = 1'b0;
    bus.inhibit    = 1'b0;

    // Pulse offsets: first high bit i -> pulse observed at step i+7.
    vecs[0]  = mk(span(0, 9), '0, '0, K_N, 7, K_NONE, 0);
    vecs[1]  = mk('0, span(0, 2) | span(4, 5) | span(7, 14), '0, K_D, 14, K_NONE, 0);
    vecs[2]  = mk('0, span(0, 7), span(0, 15), K_R, 7, K_NONE, 0);
    vecs[3]  = mk(span(0, 7), span(0, 7), '0, K_R, 7, K_NONE, 0);
    vecs[4]  = mk(span(0, 9) | span(12, 12), span(1, 8), '0, K_N, 7, K_D, 8);
    vecs[5]  = mk(span(0, 3), '0, '0, K_N, 7, K_NONE, 0);
    vecs[6]  = mk(span(0, 2), span(10, 12), '0, K_NONE, 0, K_NONE, 0);
    vecs[7]  = mk(span(0, 7), '0, span(0, 5), K_N, 7, K_NONE, 0);
    vecs[8]  = mk('0, span(0, 7), span(6, 6), K_R, 7, K_NONE, 0);
    vecs[9]  = mk(span(0, 7), span(0, 7), span(0, 31), K_R, 7, K_NONE, 0);
    vecs[10] = mk(span(0, 5), span(12, 17), '0, K_N, 7, K_D, 19);
    vecs[11] = mk(span(1, 9), span(0, 8), '0, K_D, 7, K_N, 8);

    repeat (3) @(negedge clk);
    expect_val("reset_outputs", int'(obs_now()), 0);
`ifdef COIN_AUDIT_EN
    expect_val("reset_nickel_total", int'(bus.nickel_total), 0);
`endif
    reset = 1'b0;

    for (int s = 0; s < NV; s++) begin
      base = g + 1;
      if (vecs[s].k0 != K_NONE) push_exp(vecs[s].k0, base + vecs[s].c0);
      if (vecs[s].k1 != K_NONE) push_exp(vecs[s].k1, base + vecs[s].c1);
      for (int j = 0; j < SLEN; j++)
        step(vecs[s].n[j], vecs[s].d[j], vecs[s].inh[j], 1'b0);
    end

`ifdef COIN_AUDIT_EN
    expect_val("nickel_total", int'(bus.nickel_total), exp_n);
    expect_val("dime_total", int'(bus.dime_total), exp_d);
    expect_val("reject_total", int'(bus.reject_total), exp_r);
`endif

    // Reset two cycles into a nickel debounce; the coin is re-debounced from
    // the first post-reset sample (step 3) and counted once.
    base = g + 1;
    push_exp(K_N, base + 10);
    for (int j = 0; j < SLEN; j++) begin
      step(j < 16, 1'b0, 1'b0, j == 2);
      if (j == 3) begin
        expect_val("post_reset_outputs", int'(obs_now()), 0);
`ifdef COIN_AUDIT_EN
        expect_val("post_reset_nickel_total", int'(bus.nickel_total), 0);
`endif
      end
    end
`ifdef COIN_AUDIT_EN
    expect_val("reset_case_nickel_total", int'(bus.nickel_total), 1);
    expect_val("reset_case_reject_total", int'(bus.reject_total), 0);
`endif

    step(1'b0, 1'b0, 1'b0, 1'b0);
    expect_val("scoreboard_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
Name: coin_acceptor

Overview:
- Front-end stage feeding the vending FSM's `nickel`/`dime` inputs.
- Synchronizes and debounces two raw, asynchronous coin-slot sensor lines.
- Emits exactly one clean single-cycle pulse per accepted coin.
- Rejects coins that arrive while the downstream is inhibited, or that arrive on both slots at once.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive synchronized-stable cycles needed to accept a level change (min 2).
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width (localparam, derived).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- nickel_raw  in  1  asynchronous nickel-slot sensor, high while a coin is in the slot.
- dime_raw  in  1  asynchronous dime-slot sensor, high while a coin is in the slot.
- inhibit  in  1  downstream busy (tied to the vending FSM `open`); coins committed while high are rejected.
- nickel  out  1  one-cycle pulse per accepted nickel.
- dime  out  1  one-cycle pulse per accepted dime.
- coin_reject  out  1  one-cycle pulse that drives the coin-return gate.

Behaviour:
- Clock and reset: clk is the clock; reset is synchronous and active-high. All flops clear on the reset edge. After reset: nickel=0, dime=0, coin_reject=0, synchronizers=0, channel FSMs in LOW, counters=0.
- Synchronizer: each raw line passes through a 2-flop synchronizer; s = second stage.
- Per-channel FSM (4 states):
  - LOW: stable low. s=1 -> RISE, counter=1.
  - RISE: s=1 -> counter++; when counter reaches DEBOUNCE_CYCLES, go to HIGH and raise a commit strobe for one cycle. s=0 -> back to LOW, counter=0 (glitch discarded).
  - HIGH: stable high. s=0 -> FALL, counter=1.
  - FALL: s=0 -> counter++; when counter reaches DEBOUNCE_CYCLES, go to LOW. s=1 -> back to HIGH, counter=0.
- A channel commits at most once per LOW->HIGH excursion. Holding a coin in the slot never re-pulses.
- Output stage (registered, one cycle after the commit strobe):
  - Only nickel commit, inhibit=0 -> nickel=1.
  - Only dime commit, inhibit=0 -> dime=1.
  - Any commit with inhibit=1 -> coin_reject=1; nickel and dime stay 0.
  - Both channels commit in the same cycle -> coin_reject=1 only, regardless of inhibit.
  - Otherwise all three outputs are 0.
- inhibit is sampled in the commit cycle only.
- Invariant: at most one of nickel, dime, coin_reject is high in any cycle, and each pulse is exactly 1 cycle wide.
- Latency: raw first sampled high at edge E and held stable -> output pulse is high during the cycle following edge E+DEBOUNCE_CYCLES+2. With DEBOUNCE_CYCLES=4 this is edge E+6.
- Commits on different cycles are handled independently; a nickel followed by a dime one cycle later gives two separate pulses.
- Reset mid-debounce discards partial progress. If a raw line is still high after reset, it is debounced afresh and yields a pulse (coin counted once).
- Counter never exceeds DEBOUNCE_CYCLES; no wrap-around is possible.

Optional Feature:
- Macro: COIN_AUDIT_EN.
- When defined, adds three 16-bit outputs: nickel_total, dime_total, reject_total.
  - Each increments in the same cycle as its corresponding pulse.
  - Each saturates at 16'hFFFF.
  - Each clears on reset.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package coin_acceptor_pkg holds:
  - the channel state typedef: LOW=2'b00, RISE=2'b01, HIGH=2'b11, FALL=2'b10;
  - the default DEBOUNCE_CYCLES constant;
  - the audit counter width (16).
- Sub-module coin_debounce (synchronizer + channel FSM + counter, output = commit strobe) is instantiated twice.
- The top level holds the arbitration/inhibit output stage and the optional audit counters.

Test Plan (DEBOUNCE_CYCLES=4):
1. Clean nickel: nickel_raw high for 10 cycles, inhibit=0 -> exactly one nickel pulse, 6 cycles after the first high sample; dime=0 and coin_reject=0 throughout.
2. Glitch rejection: dime_raw high for 3 cycles, low, then high for 2 cycles -> no dime pulse; dime_raw then held 8 cycles -> one dime pulse.
3. Inhibited coin: inhibit=1, dime_raw held 8 cycles -> one coin_reject pulse; dime never asserts; releasing inhibit afterwards gives no late dime pulse.
4. Simultaneous coins: both raw lines rise on the same edge and are held 8 cycles -> single coin_reject pulse; nickel=0 and dime=0.
5. Staggered coins plus bounce on release: nickel rises, dime rises 1 cycle later; nickel bounces low 2 cycles during FALL then settles -> nickel pulse then dime pulse on consecutive cycles, no second nickel pulse.
6. Reset mid-debounce: nickel_raw high, reset pulsed at 2 cycles in, raw still held -> no pulse before reset; one nickel pulse 6 cycles after the first post-reset sample. With COIN_AUDIT_EN, nickel_total reads 1.
